// File: rtl/serv_mem_sched_if.sv
// Requester and memory-port bundle for serv_mem_sched.
// Hart h owns the slice [32h+31:32h] of each address/data bus and bit h of each strobe.
interface serv_mem_sched_if #(
  parameter int NUM_HARTS = 2
);
  logic [32*NUM_HARTS-1:0] i_ibus_adr;
  logic [NUM_HARTS-1:0]    i_ibus_cyc;
  logic [NUM_HARTS-1:0]    o_ibus_ack;
  logic [32*NUM_HARTS-1:0] i_dbus_adr;
  logic [32*NUM_HARTS-1:0] i_dbus_dat;
  logic [4*NUM_HARTS-1:0]  i_dbus_sel;
  logic [NUM_HARTS-1:0]    i_dbus_we;
  logic [NUM_HARTS-1:0]    i_dbus_cyc;
  logic [NUM_HARTS-1:0]    o_dbus_ack;
  logic [31:0]             o_rdt;
  logic [31:0]             o_wb_adr;
  logic [31:0]             o_wb_dat;
  logic [3:0]              o_wb_sel;
  logic                    o_wb_we;
  logic                    o_wb_cyc;
  logic [31:0]             i_wb_rdt;
  logic                    i_wb_ack;
  logic                    o_timeout;

  // Scheduler side: takes hart requests and memory responses.
  modport slave (
    input  i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel,
           i_dbus_we, i_dbus_cyc, i_wb_rdt, i_wb_ack,
    output o_ibus_ack, o_dbus_ack, o_rdt, o_wb_adr, o_wb_dat, o_wb_sel,
           o_wb_we, o_wb_cyc, o_timeout
  );

  // Environment side: drives hart requests and memory responses.
  modport master (
    output i_ibus_adr, i_ibus_cyc, i_dbus_adr, i_dbus_dat, i_dbus_sel,
           i_dbus_we, i_dbus_cyc, i_wb_rdt, i_wb_ack,
    input  o_ibus_ack, o_dbus_ack, o_rdt, o_wb_adr, o_wb_dat, o_wb_sel,
           o_wb_we, o_wb_cyc, o_timeout
  );
endinterface

// File: rtl/serv_mem_sched.sv
// Round-robin share of one Wishbone memory port among the ibus/dbus of NUM_HARTS
// SERV cores. One transaction in flight; dbus beats ibus inside a hart; optional
// ack watchdog. A hart that was just served stays blocked until its cyc drops.
module serv_mem_sched #(
  parameter int NUM_HARTS = 2,
  parameter int TIMEOUT   = 255
) (
  input logic              i_clk,
  input logic              i_rst,
  serv_mem_sched_if.slave  bus
);
  localparam int HW    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam int CW    = TO_EN ? $clog2(TIMEOUT + 1) : 1;
  // Expiry is decided one cycle before the count would reach TIMEOUT, so the
  // registered pulse lands TIMEOUT cycles after o_wb_cyc rises.
  localparam int TMAX  = TO_EN ? TIMEOUT - 1 : 0;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t               r_state, w_next;
  logic [NUM_HARTS-1:0] w_req, w_elig, r_blocked;
  logic [HW-1:0]        r_last, r_owner, w_gnt_idx;
  logic                 w_gnt_any, w_grant, w_done, w_expire;
  logic                 r_src_d;
  logic [CW-1:0]        r_cnt;

  logic [31:0]          r_wb_adr, r_wb_dat, r_rdt;
  logic [3:0]           r_wb_sel;
  logic                 r_wb_we, r_wb_cyc, r_timeout;
  logic [NUM_HARTS-1:0] r_ibus_ack, r_dbus_ack;

  logic [31:0]          w_iadr [NUM_HARTS];
  logic [31:0]          w_dadr [NUM_HARTS];
  logic [31:0]          w_ddat [NUM_HARTS];
  logic [3:0]           w_dsel [NUM_HARTS];

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_unpack
    assign w_iadr[h] = bus.i_ibus_adr[32*h +: 32];
    assign w_dadr[h] = bus.i_dbus_adr[32*h +: 32];
    assign w_ddat[h] = bus.i_dbus_dat[32*h +: 32];
    assign w_dsel[h] = bus.i_dbus_sel[4*h +: 4];
  end

  assign w_req  = bus.i_ibus_cyc | bus.i_dbus_cyc;
  assign w_elig = w_req & ~r_blocked;

  assign bus.o_wb_adr   = r_wb_adr;
  assign bus.o_wb_dat   = r_wb_dat;
  assign bus.o_wb_sel   = r_wb_sel;
  assign bus.o_wb_we    = r_wb_we;
  assign bus.o_wb_cyc   = r_wb_cyc;
  assign bus.o_rdt      = r_rdt;
  assign bus.o_ibus_ack = r_ibus_ack;
  assign bus.o_dbus_ack = r_dbus_ack;
  assign bus.o_timeout  = r_timeout;

  // Round-robin pick: first eligible hart scanning from last+1.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = 1; k <= NUM_HARTS; k++) begin
      idx = (int'(r_last) + k) % NUM_HARTS;
      if (!w_gnt_any && w_elig[idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = HW'(idx);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state: grant in IDLE, finish on ack or watchdog expiry in BUSY.
  always_comb begin
    w_next   = r_state;
    w_grant  = 1'b0;
    w_done   = 1'b0;
    w_expire = 1'b0;
    case (r_state)
      S_IDLE: if (w_gnt_any) begin
        w_grant = 1'b1;
        w_next  = S_BUSY;
      end
      S_BUSY: begin
        // A real ack on the expiry cycle wins; no timeout is reported then.
        w_expire = TO_EN && !bus.i_wb_ack && (r_cnt == CW'(TMAX));
        if (bus.i_wb_ack || w_expire) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: latch the winner's request, hold it while BUSY, return the response.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wb_adr   <= '0;
      r_wb_dat   <= '0;
      r_wb_sel   <= '0;
      r_wb_we    <= 1'b0;
      r_wb_cyc   <= 1'b0;
      r_rdt      <= '0;
      r_ibus_ack <= '0;
      r_dbus_ack <= '0;
      r_timeout  <= 1'b0;
      r_blocked  <= '0;
      r_last     <= HW'(NUM_HARTS - 1);
      r_owner    <= '0;
      r_src_d    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_ibus_ack <= '0;
      r_dbus_ack <= '0;
      r_timeout  <= 1'b0;
      // A hart whose request has dropped may be granted again.
      r_blocked  <= r_blocked & w_req;
      if (w_grant) begin
        r_last   <= w_gnt_idx;
        r_owner  <= w_gnt_idx;
        r_cnt    <= '0;
        r_wb_cyc <= 1'b1;
        if (bus.i_dbus_cyc[w_gnt_idx]) begin
          r_src_d  <= 1'b1;
          r_wb_adr <= w_dadr[w_gnt_idx];
          r_wb_dat <= w_ddat[w_gnt_idx];
          r_wb_sel <= w_dsel[w_gnt_idx];
          r_wb_we  <= bus.i_dbus_we[w_gnt_idx];
        end else begin
          r_src_d  <= 1'b0;
          r_wb_adr <= w_iadr[w_gnt_idx];
          r_wb_dat <= '0;
          r_wb_sel <= 4'hF;
          r_wb_we  <= 1'b0;
        end
      end else if (w_done) begin
        r_wb_cyc  <= 1'b0;
        r_rdt     <= w_expire ? 32'h0 : bus.i_wb_rdt;
        r_timeout <= w_expire;
        r_blocked[r_owner] <= 1'b1;
        if (r_src_d) r_dbus_ack[r_owner] <= 1'b1;
        else         r_ibus_ack[r_owner] <= 1'b1;
      end else if (r_state == S_BUSY && TO_EN) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/serv_mem_sched.md
# serv_mem_sched

Round-robin scheduler that shares one Wishbone memory port between the instruction and data buses of `NUM_HARTS` SERV cores. Each hart issues at most one transaction at a time; dbus wins over ibus within a hart. Transactions are registered and optionally bounded by a timeout watchdog. The block sits between the cores' ibus/dbus ports and the single-port system RAM or interconnect in multi-hart builds.

## Interface
- `NUM_HARTS`, 2: number of harts, 2..8.
- `TIMEOUT`, 255: maximum cycles a granted transaction waits for ack; 0 disables the watchdog.

- `i_clk` in 1: clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_ibus_adr` in 32*N: per-hart fetch address; hart h at bits [32h+31:32h].
- `i_ibus_cyc` in N: per-hart fetch request.
- `o_ibus_ack` out N: per-hart fetch ack, one-cycle pulse.
- `i_dbus_adr` in 32*N: per-hart data address.
- `i_dbus_dat` in 32*N: per-hart write data.
- `i_dbus_sel` in 4*N: per-hart byte enables.
- `i_dbus_we` in N: per-hart write enable.
- `i_dbus_cyc` in N: per-hart data request.
- `o_dbus_ack` out N: per-hart data ack, one-cycle pulse.
- `o_rdt` out 32: read data, shared by all harts, valid with any ack.
- `o_wb_adr` out 32, `o_wb_dat` out 32, `o_wb_sel` out 4, `o_wb_we` out 1, `o_wb_cyc` out 1: memory port master.
- `i_wb_rdt` in 32, `i_wb_ack` in 1: memory port response.
- `o_timeout` out 1: one-cycle pulse when the watchdog terminates a transaction.

## Operation
- `req[h] = i_ibus_cyc[h] | i_dbus_cyc[h]`. `eligible[h] = req[h] & !blocked[h]`.
- FSM states: IDLE and BUSY.
- IDLE:
  - If any `eligible[h]` is set, the grant goes to the first eligible hart scanning from `last+1` modulo `NUM_HARTS`.
  - `last` is updated to the granted hart.
  - Source is dbus if `i_dbus_cyc[h]`, else ibus.
  - Address, data, sel and we are latched into the `o_wb_*` registers. For ibus the latched values are we=0, sel=4'hF, dat=0.
  - `o_wb_cyc` is set and the FSM goes to BUSY.
- BUSY:
  - Master outputs are held stable.
  - On `i_wb_ack`: `o_rdt <= i_wb_rdt`. The owner's ibus or dbus ack register is set for one cycle. `o_wb_cyc` is cleared, `blocked[owner]` is set, and the FSM returns to IDLE.
- Watchdog:
  - The counter clears on grant and increments each BUSY cycle without ack.
  - When it reaches `TIMEOUT` (and `TIMEOUT != 0`), the transaction completes as if acked: `o_rdt <= 0`, owner ack pulse, `o_timeout` pulse.
  - Ack in the same cycle as expiry counts as a normal ack; there is no timeout pulse.
- `blocked[h]` clears in any cycle where `req[h] == 0`. This prevents re-granting a hart whose cyc lingers after ack; SERV dbus_cyc stays high until the RF write starts.
- `i_wb_ack` while IDLE is ignored.
- Requester inputs are sampled only in IDLE. Changes during BUSY have no effect.

## Timing
- Reset values:
  - `o_wb_cyc=0`, `o_wb_we=0`, `o_wb_adr=0`, `o_wb_dat=0`, `o_wb_sel=0`.
  - `o_ibus_ack=0`, `o_dbus_ack=0`, `o_rdt=0`, `o_timeout=0`.
  - `blocked=0`, `last=NUM_HARTS-1` (hart 0 wins first), counter=0, FSM in IDLE.
- Assertion of `i_rst` mid-transaction drops `o_wb_cyc` immediately and no ack is issued. After release, arbitration restarts from hart 0.
- Request seen in IDLE at cycle t gives `o_wb_cyc` high at t+1.
- `i_wb_ack` at cycle u gives the owner's ack and `o_rdt` at u+1, with `o_wb_cyc` low at u+1.
- Earliest next grant is decided at u+1, with `o_wb_cyc` high at u+2. Minimum gap between transactions is one cycle.
- Timeout:
  - Grant at t and no ack gives `o_timeout` and owner ack at t+1+`TIMEOUT`.
  - Counter width is `$clog2(TIMEOUT+1)` and it never wraps.
- Acks are exactly one cycle wide. At most one bit of `o_ibus_ack | o_dbus_ack` is set per cycle.

## Test plan
- Single hart 0 ibus fetch at 0x100, memory acks 2 cycles after cyc with 0x00000013. Required: `o_wb_adr=0x100`, `o_wb_we=0`, `o_wb_sel=F`; `o_ibus_ack[0]` for one cycle with `o_rdt=0x13`.
- Both harts request continuously, each dropping cyc one cycle after ack. Required: grants alternate 0,1,0,1, with one idle cycle between transactions.
- Hart 1 dbus write 0xDEADBEEF to 0x2000 with sel=4'b0011 and `i_dbus_cyc` held 3 cycles after ack, hart 0 idle. Required: exactly one write on the memory port; no regrant until cyc drops.
- `TIMEOUT=4`, memory never acks. Required: `o_timeout` and `o_dbus_ack` pulse 5 cycles after grant, `o_rdt=0`. Repeat with ack arriving on the expiry cycle: no timeout pulse.
- Assert `i_rst` while BUSY. Required: `o_wb_cyc` low in the same cycle, no ack pulse; after release, hart 0 is granted first with both harts requesting.
- Hart 0 asserts ibus and dbus cyc together. Required: dbus transaction issued, `o_dbus_ack[0]` pulses, `o_ibus_ack[0]` stays 0.
